// File: rtl/fifo_arb_pkg.sv
// ============================================================================
//  Module   : fifo_arb_pkg
//  Purpose  : Shared types, constants and the round-robin search helper for
//             the FIFO push arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef FIFO_DWIDTH
`define FIFO_DWIDTH 8
`endif

`ifndef ARB_QWID
`define ARB_QWID 2
`endif

package fifo_arb_pkg;

    // Arbiter modes: free round-robin, or locked onto one burst owner.
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // Largest supported requester count; the helper works on this width.
    localparam int c_max_req = 8;

    // Default outstanding-entry quota: all ones in a QWID-bit counter.
    localparam int c_quota_default = (1 << `ARB_QWID) - 1;

    // Index of the first set bit of 'eligible' at or after 'ptr', wrapping
    // modulo nreq. Returns 0 when nothing is eligible; callers qualify the
    // result with a separate "any eligible" flag.
    function automatic logic [2:0] rr_first(
        input logic [c_max_req-1:0] eligible,
        input logic [2:0]           ptr,
        input int                   nreq
    );
        int   w_idx;
        logic w_found;
        rr_first = '0;
        w_found  = 1'b0;
        for (int k = 0; k < c_max_req; k++) begin
            if (k < nreq) begin
                w_idx = (int'(ptr) + k) % nreq;
                if (!w_found && eligible[3'(w_idx)]) begin
                    w_found  = 1'b1;
                    rr_first = 3'(w_idx);
                end
            end
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
//  Module   : rr_pick
//  Purpose  : Combinational rotate-priority encoder. Picks the first eligible
//             requester at or after ptr and returns it one-hot and as an id.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] eligible,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  id,
    output logic            any
);
    import fifo_arb_pkg::*;

    logic [c_max_req-1:0] w_elig_ext;
    logic [2:0]           w_ptr_ext;
    logic [2:0]           w_first;

    // Widen to the helper's fixed width, search, and narrow the result back.
    always_comb begin
        w_elig_ext               = '0;
        w_elig_ext[NREQ-1:0]     = eligible;
        w_ptr_ext                = 3'(ptr);
        w_first                  = rr_first(w_elig_ext, w_ptr_ext, NREQ);
        any                      = |eligible;
        id                       = IDW'(w_first);
        gnt                      = '0;
        if (any) begin
            gnt[id] = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fifo_rr_arbiter.sv
// ============================================================================
//  Module   : fifo_rr_arbiter
//  Purpose  : Round-robin push arbiter sharing one FIFO between NREQ
//             requesters, with per-requester outstanding quotas and locked
//             multi-beat bursts.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = `FIFO_DWIDTH,
    parameter int QWID  = `ARB_QWID,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       last,
    input  logic [NREQ*WIDTH-1:0] data_in,
    input  logic                  full,
    input  logic                  pop,
    input  logic [IDW-1:0]        pop_id,
    output logic [NREQ-1:0]       gnt,
    output logic                  push,
    output logic [WIDTH-1:0]      push_data,
    output logic [IDW-1:0]        push_id,
    output logic [NREQ*QWID-1:0]  cnt,
    output logic                  locked
);
    import fifo_arb_pkg::*;

    localparam logic [QWID-1:0] c_quota = '1;

    arb_state_t      r_state;
    arb_state_t      w_state_nxt;
    logic [IDW-1:0]  r_owner;
    logic [IDW-1:0]  w_owner_nxt;
    logic [IDW-1:0]  r_ptr;
    logic [IDW-1:0]  w_ptr_nxt;
    logic [QWID-1:0] r_cnt [NREQ];

    logic [NREQ-1:0] w_elig;
    logic [NREQ-1:0] w_dec;
    logic [NREQ-1:0] w_pick_gnt;
    logic [IDW-1:0]  w_pick_id;
    logic            w_pick_any;
    logic [IDW-1:0]  w_win;

    // Per-requester eligibility, legal decrement and flattened count view.
    for (genvar i = 0; i < NREQ; i++) begin : g_req
        assign w_elig[i]               = req[i] && (r_cnt[i] != c_quota);
        assign w_dec[i]                = pop && (pop_id == IDW'(i)) && (r_cnt[i] != '0);
        assign cnt[i*QWID +: QWID]     = r_cnt[i];
    end

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .eligible (w_elig),
        .ptr      (r_ptr),
        .gnt      (w_pick_gnt),
        .id       (w_pick_id),
        .any      (w_pick_any)
    );

    // State, owner and rotation pointer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_owner <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // Grant selection and next-state logic; nothing is granted in reset or
    // while the FIFO is full, and a full FIFO never breaks a lock.
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        w_win       = '0;
        gnt         = '0;
        if (rst && !full) begin
            case (r_state)
                IDLE: begin
                    if (w_pick_any) begin
                        gnt   = w_pick_gnt;
                        w_win = w_pick_id;
                        w_ptr_nxt = (w_pick_id == IDW'(NREQ - 1)) ? '0 : w_pick_id + 1'b1;
                        if (!last[w_pick_id]) begin
                            w_state_nxt = LOCKED;
                            w_owner_nxt = w_pick_id;
                        end
                    end
                end
                LOCKED: begin
                    if (w_elig[r_owner]) begin
                        gnt[r_owner] = 1'b1;
                        w_win        = r_owner;
                        if (last[r_owner]) begin
                            w_state_nxt = IDLE;
                        end
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    // Push port: mux the granted requester's data, zero when idle.
    always_comb begin
        push      = |gnt;
        push_id   = push ? w_win : '0;
        push_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                push_data = data_in[i*WIDTH +: WIDTH];
            end
        end
    end

    // Outstanding counters: a same-cycle grant and pop cancel out; a pop of
    // an empty counter is ignored so the count never wraps below zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREQ; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (gnt[i] && !w_dec[i]) begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end else if (w_dec[i] && !gnt[i]) begin
                    r_cnt[i] <= r_cnt[i] - 1'b1;
                end
            end
        end
    end

    assign locked = (r_state == LOCKED);

`ifndef SYNTHESIS
    logic w_pop_ok;

    // A pop must name a requester that actually has entries outstanding.
    always_comb begin
        w_pop_ok = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if ((pop_id == IDW'(i)) && (r_cnt[i] != '0)) begin
                w_pop_ok = 1'b1;
            end
        end
    end

    a_gnt_onehot : assert property (@(posedge clk) disable iff (!rst) $onehot0(gnt));
    a_no_push_full : assert property (@(posedge clk) disable iff (!rst) !(push && full));
    m_pop_legal : assume property (@(posedge clk) disable iff (!rst) pop |-> w_pop_ok);

    for (genvar i = 0; i < NREQ; i++) begin : g_no_ovf
        a_cnt_no_ovf : assert property (@(posedge clk) disable iff (!rst)
                                        (r_cnt[i] == c_quota) |-> !gnt[i]);
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_rr_arbiter.sv
// ============================================================================
//  Module   : tb_fifo_rr_arbiter
//  Purpose  : Scoreboard bench for fifo_rr_arbiter with a queue-based
//             reference model and directed plus randomized traffic.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_rr_arbiter;
    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int QWID  = 2;
    localparam int IDW   = 2;
    localparam int QUOTA = 3;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       last;
    logic [NREQ*WIDTH-1:0] data_in;
    logic                  full;
    logic                  pop;
    logic [IDW-1:0]        pop_id;
    logic [NREQ-1:0]       gnt;
    logic                  push;
    logic [WIDTH-1:0]      push_data;
    logic [IDW-1:0]        push_id;
    logic [NREQ*QWID-1:0]  cnt;
    logic                  locked;

    fifo_rr_arbiter #(
        .NREQ  (NREQ),
        .WIDTH (WIDTH),
        .QWID  (QWID)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .last      (last),
        .data_in   (data_in),
        .full      (full),
        .pop       (pop),
        .pop_id    (pop_id),
        .gnt       (gnt),
        .push      (push),
        .push_data (push_data),
        .push_id   (push_id),
        .cnt       (cnt),
        .locked    (locked)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [NREQ-1:0]      gnt;
        logic [NREQ*QWID-1:0] cnt;
        logic                 locked;
    } status_t;

    typedef struct {
        int               id;
        logic [WIDTH-1:0] data;
    } xfer_t;

    status_t status_q[$];
    xfer_t   xfer_q[$];

    // Reference model: counts, rotation start, burst owner (-1 = none) and
    // the ids currently held in the shared FIFO, oldest first.
    int               m_cnt [NREQ];
    int               m_ptr;
    int               m_owner;
    int               fifo_ids[$];
    logic [NREQ-1:0]  prev_req;
    logic [NREQ-1:0]  prev_gnt;
    logic [WIDTH-1:0] req_data [NREQ];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
        m_ptr   = 0;
        m_owner = -1;
        fifo_ids.delete();
        prev_req = '0;
        prev_gnt = '0;
    endtask

    // Drive one cycle of inputs, predict the outcome, queue expectations.
    task automatic cycle(input logic [NREQ-1:0] r, input logic [NREQ-1:0] l,
                         input logic f, input logic pen);
        int              win;
        int              head;
        logic [NREQ-1:0] eg;
        status_t         s;
        xfer_t           x;
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (!(prev_req[i] && !prev_gnt[i])) req_data[i] = WIDTH'($urandom);
            data_in[i*WIDTH +: WIDTH] = req_data[i];
        end
        req  = r;
        last = l;
        full = f;
        pop  = pen && (fifo_ids.size() > 0) && ($urandom_range(0, 1) == 1);
        pop_id = pop ? IDW'(fifo_ids[0]) : IDW'($urandom_range(0, NREQ - 1));

        win = -1;
        if (!f) begin
            if (m_owner >= 0) begin
                if (r[m_owner] && m_cnt[m_owner] < QUOTA) win = m_owner;
            end else begin
                for (int k = 0; k < NREQ; k++) begin
                    int idx = (m_ptr + k) % NREQ;
                    if (win < 0 && r[idx] && m_cnt[idx] < QUOTA) win = idx;
                end
            end
        end
        eg = '0;
        if (win >= 0) eg[win] = 1'b1;

        s.gnt    = eg;
        s.locked = (m_owner >= 0);
        for (int i = 0; i < NREQ; i++) s.cnt[i*QWID +: QWID] = QWID'(m_cnt[i]);
        status_q.push_back(s);
        if (win >= 0) begin
            x.id   = win;
            x.data = req_data[win];
            xfer_q.push_back(x);
        end

        if (pop) begin
            head = fifo_ids.pop_front();
            m_cnt[head]--;
        end
        if (win >= 0) begin
            m_cnt[win]++;
            fifo_ids.push_back(win);
            if (m_owner < 0) begin
                m_ptr = (win + 1) % NREQ;
                if (!l[win]) m_owner = win;
            end else if (l[win]) begin
                m_owner = -1;
            end
        end
        prev_req = r;
        prev_gnt = eg;
    endtask

    task automatic drain();
        for (int n = 0; n < 200 && fifo_ids.size() > 0; n++) cycle('0, '0, 1'b0, 1'b1);
    endtask

    // Monitor: per-cycle status always, transfer data whenever the DUT pushes.
    initial begin
        status_t s;
        xfer_t   x;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                if (status_q.size() > 0) begin
                    s = status_q.pop_front();
                    chk("gnt", 32'(gnt), 32'(s.gnt));
                    chk("cnt", 32'(cnt), 32'(s.cnt));
                    chk("locked", 32'(locked), 32'(s.locked));
                end
                if (push === 1'b1) begin
                    if (xfer_q.size() == 0) begin
                        chk("unexpected_push", 32'(push), 32'd0);
                    end else begin
                        x = xfer_q.pop_front();
                        chk("push_id", 32'(push_id), 32'(x.id));
                        chk("push_data", 32'(push_data), 32'(x.data));
                    end
                end
            end
        end
    end

    initial begin
        logic [NREQ-1:0] r;
        logic [NREQ-1:0] l;
        rst = 1'b0; req = '0; last = '0; full = 1'b0; pop = 1'b0; pop_id = '0; data_in = '0;
        for (int i = 0; i < NREQ; i++) req_data[i] = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_push", 32'(push), 32'd0);
        chk("rst_push_data", 32'(push_data), 32'd0);
        chk("rst_push_id", 32'(push_id), 32'd0);
        chk("rst_cnt", 32'(cnt), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        // Rotation: all requesting single beats, counts climb to 2 each.
        repeat (8) cycle(4'b1111, 4'b1111, 1'b0, 1'b0);
        cycle('0, '0, 1'b0, 1'b0);
        chk("rotation_cnt", 32'(cnt), 32'h00AA);

        // Burst lock from requester 0 while 1 also requests.
        drain();
        cycle(4'b0011, 4'b0010, 1'b0, 1'b0);
        cycle(4'b0011, 4'b0010, 1'b0, 1'b0);
        cycle(4'b0011, 4'b0011, 1'b0, 1'b0);
        cycle(4'b0010, 4'b0010, 1'b0, 1'b0);

        // Full stall then release.
        drain();
        repeat (3) cycle(4'b0100, 4'b0100, 1'b1, 1'b0);
        cycle(4'b0100, 4'b0100, 1'b0, 1'b0);

        // Quota on requester 2, then others still served.
        drain();
        repeat (3) cycle(4'b0100, 4'b0100, 1'b0, 1'b0);
        repeat (3) cycle(4'b0110, 4'b0110, 1'b0, 1'b0);
        repeat (4) cycle(4'b0100, 4'b0100, 1'b0, 1'b1);

        // Randomized traffic with held requests and random full/pop.
        drain();
        for (int n = 0; n < 800; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (prev_req[i] && !prev_gnt[i]) begin
                    r[i] = prev_req[i];
                    l[i] = last[i];
                end else begin
                    r[i] = ($urandom_range(0, 9) < 6);
                    l[i] = ($urandom_range(0, 9) < 6);
                end
            end
            cycle(r, l, ($urandom_range(0, 3) == 0), 1'b1);
        end

        // Reset in the middle of a locked burst.
        drain();
        cycle(4'b0001, 4'b0000, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_gnt", 32'(gnt), 32'd0);
        chk("midrst_push", 32'(push), 32'd0);
        chk("midrst_locked", 32'(locked), 32'd0);
        chk("midrst_cnt", 32'(cnt), 32'd0);
        model_reset();
        req = '0;
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (4) cycle(4'b1111, 4'b1111, 1'b0, 1'b0);

        cycle('0, '0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        chk("xfer_q_empty", 32'(xfer_q.size()), 32'd0);
        chk("status_q_empty", 32'(status_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
